// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter onto a single fixed-latency memory port.
// Optional macro ARB_RR_EN: round-robin on conflict; otherwise the data stage always wins.
module mem_arbiter #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      r_state;
  state_e      w_state_d;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_we;
  logic        r_gnt_dm;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        w_any_req;
  logic        w_gnt_dm;
  logic        w_last_cycle;

  assign w_any_req    = if_req | dm_req;
  assign w_last_cycle = (r_state == StBusy) && (r_cnt == 4'd0);

`ifdef ARB_RR_EN
  logic r_last_dm;

  // On conflict, prefer whichever requester was not served last.
  assign w_gnt_dm = dm_req & (~if_req | ~r_last_dm);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_dm <= 1'b0;
    end else if (r_state == StIdle && w_any_req) begin
      r_last_dm <= w_gnt_dm;
    end
  end
`else
  assign w_gnt_dm = dm_req;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: if (w_any_req) w_state_d = StBusy;
      StBusy: if (r_cnt == 4'd0) w_state_d = StDone;
      StDone: w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_we       <= 1'b0;
      r_gnt_dm   <= 1'b0;
      r_if_rdata <= 32'd0;
      r_dm_rdata <= 32'd0;
    end else begin
      if (r_state == StIdle && w_any_req) begin
        r_cnt    <= 4'(LATENCY - 1);
        r_gnt_dm <= w_gnt_dm;
        r_addr   <= w_gnt_dm ? dm_addr : if_addr;
        r_wdata  <= w_gnt_dm ? dm_wdata : 32'd0;
        r_we     <= w_gnt_dm & dm_we;
      end else if (r_state == StBusy && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data lands only in the register of the requester being served.
      if (w_last_cycle && !r_we) begin
        if (r_gnt_dm) r_dm_rdata <= mem_rdata;
        else          r_if_rdata <= mem_rdata;
      end
    end
  end

  assign mem_en    = (r_state == StBusy);
  assign mem_we    = (r_state == StBusy) & r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ready = (r_state == StDone) & ~r_gnt_dm;
  assign dm_ready = (r_state == StDone) & r_gnt_dm;
  assign if_rdata = r_if_rdata;
  assign dm_rdata = r_dm_rdata;

  assign stall_f = if_req & ~if_ready;
  assign stall_m = dm_req & ~dm_ready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter at LATENCY=2.
// Expectations for the held-conflict test follow ARB_RR_EN when it is defined.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        stall_f;
  logic        stall_m;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(2)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .stall_f   (stall_f),
    .stall_m   (stall_m)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
    tick(); tick();
    check("rst_if_rdata", if_rdata, 32'h0);
    check("rst_dm_rdata", dm_rdata, 32'h0);
    check("rst_if_ready", {31'd0, if_ready}, 32'd0);
    check("rst_dm_ready", {31'd0, dm_ready}, 32'd0);
    check("rst_mem_en", {31'd0, mem_en}, 32'd0);
    reset = 1'b0;
    tick();

    // Single fetch: mem_en cycles 1-2, if_ready cycle 3.
    if_req = 1'b1; if_addr = 32'h0040_0000; mem_rdata = 32'h2402_000A;
    #1;
    check("f_c0_stall_f", {31'd0, stall_f}, 32'd1);
    check("f_c0_mem_en", {31'd0, mem_en}, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("f_c%0d_mem_en", c), {31'd0, mem_en}, {31'd0, (c == 1 || c == 2)});
      check($sformatf("f_c%0d_if_ready", c), {31'd0, if_ready}, {31'd0, (c == 3)});
      if (c <= 2) begin
        check($sformatf("f_c%0d_addr", c), mem_addr, 32'h0040_0000);
        check($sformatf("f_c%0d_we", c), {31'd0, mem_we}, 32'd0);
        check($sformatf("f_c%0d_stall_f", c), {31'd0, stall_f}, 32'd1);
      end
      if (c == 3) begin
        check("f_c3_rdata", if_rdata, 32'h2402_000A);
        check("f_c3_stall_f", {31'd0, stall_f}, 32'd0);
        if_req = 1'b0;
      end
    end

    // Simultaneous fetch + load: dm first, dm_ready 3, IF granted 4, if_ready 7.
    if_req = 1'b1; if_addr = 32'h0040_0008;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h1001_0000; mem_rdata = 32'h1111_2222;
    for (int c = 1; c <= 8; c++) begin
      tick();
      check($sformatf("c_c%0d_dm_ready", c), {31'd0, dm_ready}, {31'd0, (c == 3)});
      check($sformatf("c_c%0d_if_ready", c), {31'd0, if_ready}, {31'd0, (c == 7)});
      check($sformatf("c_c%0d_mem_en", c), {31'd0, mem_en},
            {31'd0, (c == 1 || c == 2 || c == 5 || c == 6)});
      if (c == 1) check("c_c1_addr", mem_addr, 32'h1001_0000);
      if (c == 3) begin
        check("c_c3_dm_rdata", dm_rdata, 32'h1111_2222);
        check("c_c3_stall_f", {31'd0, stall_f}, 32'd1);
        dm_req = 1'b0;
        mem_rdata = 32'h3333_4444;
      end
      if (c == 5) check("c_c5_addr", mem_addr, 32'h0040_0008);
      if (c == 7) begin
        check("c_c7_if_rdata", if_rdata, 32'h3333_4444);
        check("c_c7_dm_rdata", dm_rdata, 32'h1111_2222);
        if_req = 1'b0;
      end
    end

    // Store: mem_we/mem_wdata in BUSY, dm_rdata untouched.
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h1001_0000; dm_wdata = 32'hDEAD_BEEF;
    mem_rdata = 32'hBAD0_BAD0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("s_c%0d_mem_we", c), {31'd0, mem_we}, {31'd0, (c == 1 || c == 2)});
      check($sformatf("s_c%0d_dm_ready", c), {31'd0, dm_ready}, {31'd0, (c == 3)});
      if (c <= 2) check($sformatf("s_c%0d_wdata", c), mem_wdata, 32'hDEAD_BEEF);
      if (c == 3) begin
        check("s_c3_dm_rdata", dm_rdata, 32'h1111_2222);
        dm_req = 1'b0; dm_we = 1'b0;
      end
    end

    // Load dropped mid-access still completes.
    dm_req = 1'b1; dm_addr = 32'h1001_0004; mem_rdata = 32'h7777_8888;
    tick();
    dm_req = 1'b0;
    tick();
    check("d_c2_mem_en", {31'd0, mem_en}, 32'd1);
    tick();
    check("d_c3_dm_ready", {31'd0, dm_ready}, 32'd1);
    check("d_c3_dm_rdata", dm_rdata, 32'h7777_8888);
    tick();

    // Reset in cycle 1 of a fetch aborts it; held request restarts.
    if_req = 1'b1; if_addr = 32'h0040_0004; mem_rdata = 32'h5555_6666;
    tick();
    check("r_c1_mem_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_c2_mem_en", {31'd0, mem_en}, 32'd0);
    check("r_c2_if_rdata", if_rdata, 32'h0);
    check("r_c2_dm_rdata", dm_rdata, 32'h0);
    for (int c = 3; c <= 6; c++) begin
      tick();
      check($sformatf("r_c%0d_mem_en", c), {31'd0, mem_en}, {31'd0, (c == 3 || c == 4)});
      check($sformatf("r_c%0d_if_ready", c), {31'd0, if_ready}, {31'd0, (c == 5)});
      if (c == 5) begin
        check("r_c5_if_rdata", if_rdata, 32'h5555_6666);
        if_req = 1'b0;
      end
    end

    // Both held continuously: readies every 4 cycles.
    if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0; mem_rdata = 32'h0BAD_F00D;
    for (int c = 1; c <= 16; c++) begin
      logic exp_dm;
      logic exp_if;
      tick();
`ifdef ARB_RR_EN
      exp_dm = (c == 3 || c == 11);
      exp_if = (c == 7 || c == 15);
`else
      exp_dm = (c == 3 || c == 7 || c == 11 || c == 15);
      exp_if = 1'b0;
`endif
      check($sformatf("h_c%0d_dm_ready", c), {31'd0, dm_ready}, {31'd0, exp_dm});
      check($sformatf("h_c%0d_if_ready", c), {31'd0, if_ready}, {31'd0, exp_if});
    end
    if_req = 1'b0; dm_req = 1'b0;
    tick(); tick();
    check("end_mem_en", {31'd0, mem_en}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 2, number of memory cycles per access, legal range 1..15.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port if_req  input  1  fetch-stage read request, held high until if_ready.
REQ-005 SHALL have port if_addr  input  32  fetch address.
REQ-006 SHALL have port if_rdata  output  32  fetched word, registered.
REQ-007 SHALL have port if_ready  output  1  one-cycle fetch completion pulse.
REQ-008 SHALL have port dm_req  input  1  memory-stage request, held high until dm_ready.
REQ-009 SHALL have port dm_we  input  1  memory-stage write enable (1 = store).
REQ-010 SHALL have port dm_addr / dm_wdata  input  32 each  data address, store data.
REQ-011 SHALL have port dm_rdata  output  32  load data, registered.
REQ-012 SHALL have port dm_ready  output  1  one-cycle data completion pulse.
REQ-013 SHALL have ports mem_en, mem_we  output  1 each  and mem_addr, mem_wdata  output  32 each  unified memory port.
REQ-014 SHALL have port mem_rdata  input  32  memory read data, valid in last BUSY cycle.
REQ-015 SHALL have ports stall_f, stall_m  output  1 each  pipeline stall requests to hazard logic.

Function
REQ-016 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-017 IDLE: if any request high, SHALL select grantee per REQ-023, latch its addr, we, wdata, load counter with LATENCY-1, go BUSY; else stay IDLE.
REQ-018 BUSY: SHALL drive mem_en=1 and mem_addr/mem_we/mem_wdata from latched values, stable for all BUSY cycles; mem_we=0 for fetches.
REQ-019 BUSY: counter nonzero -> decrement; counter zero -> on read capture mem_rdata into grantee's rdata register, go DONE.
REQ-020 DONE: SHALL pulse grantee's ready for exactly one cycle, then go IDLE unconditionally.
REQ-021 Latency: request sampled in IDLE at cycle 0 -> mem_en cycles 1..LATENCY -> ready at cycle LATENCY+1.
REQ-022 Outside BUSY, mem_en and mem_we SHALL be 0; mem_addr/mem_wdata don't-care.
REQ-023 Both requests in IDLE: dm granted (policy per Configuration); single request granted directly.
REQ-024 Stores SHALL leave dm_rdata unchanged; rdata registers change only on a completing read for their own requester.
REQ-025 Request dropped mid-access: access SHALL complete and ready still pulse.
REQ-026 stall_f = if_req AND NOT if_ready; stall_m = dm_req AND NOT dm_ready; combinational.
REQ-027 Requests arriving in BUSY/DONE SHALL wait; served requester's req still high in DONE is not re-granted until next IDLE.

Reset
REQ-028 On reset: state IDLE, counter 0, if_rdata=0, dm_rdata=0, if_ready=0, dm_ready=0, last-grant = IF.
REQ-029 Reset mid-BUSY SHALL abort access: mem_en=0 from the cycle after the reset edge, no ready pulse, held requests restart from IDLE.

Configuration
REQ-030 Macro ARB_RR_EN: defined -> on conflict grant the requester not granted last (last-grant register updated per grant); undefined -> fixed priority, dm always wins, no last-grant register.

Verification (LATENCY=2)
REQ-031 if_req=1 at cycle 0, if_addr=0x00400000, mem_rdata=0x2402000A -> mem_en cycles 1-2, mem_addr=0x00400000, if_ready cycle 3, if_rdata=0x2402000A, stall_f 1 on cycles 0-2.
REQ-032 if_req=dm_req=1 at cycle 0, dm_we=0, ARB_RR_EN undefined -> dm_ready cycle 3, IF granted cycle 4, if_ready cycle 7.
REQ-033 ARB_RR_EN defined, both requests held continuously -> grants dm, if, dm, if; readies at cycles 3, 7, 11, 15.
REQ-034 Store dm_addr=0x10010000, dm_wdata=0xDEADBEEF -> mem_we=1, mem_wdata=0xDEADBEEF cycles 1-2, dm_ready cycle 3, dm_rdata unchanged.
REQ-035 Reset asserted cycle 1 of a fetch -> mem_en=0 cycle 2, no if_ready; if_req held -> mem_en cycles 3-4, if_ready cycle 5.
